// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared e418 fetch definitions (widths, halt encoding, FSM states).
`default_nettype none

package instr_fetch_pkg;

  localparam int unsigned c_ADDR_W = 8;
  localparam int unsigned c_DATA_W = 16;
  localparam logic [c_DATA_W-1:0] c_HALT_WORD = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: ROM port, downstream valid/ready handshake and execute redirect of the fetch stage.
`default_nettype none

interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = c_ADDR_W,
  parameter int unsigned DATA_W = c_DATA_W
);

  logic              run;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic              halted;

  // master = fetch stage, slave = ROM/decoder/execute side
  modport master (
    input  run, rom_data, instr_ready, jump, jump_target,
    output rom_addr, instr, instr_pc, instr_valid, halted
  );

  modport slave (
    output run, rom_data, instr_ready, jump, jump_target,
    input  rom_addr, instr, instr_pc, instr_valid, halted
  );

endinterface

`default_nettype wire

// File: rtl/instr_fetch_prog_counter.sv
// instr_fetch_prog_counter: PC register with load and increment, wrapping modulo 2^ADDR_W.
`default_nettype none

module instr_fetch_prog_counter #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              load_i,
  input  wire logic [ADDR_W-1:0] load_val_i,
  input  wire logic              inc_i,
  output logic      [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // load wins over increment so a redirect always lands on its target
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// instr_fetch: e418 fetch stage - PC, instruction register, valid/ready handoff, jump flush and halt.
`default_nettype none

module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = c_ADDR_W,
  parameter int unsigned       DATA_W    = c_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = c_HALT_WORD
) (
  input  wire logic       clk,
  input  wire logic       reset,
  instr_fetch_if.master   bus
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic              halted_q, halted_d;

  logic              pc_load;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc;
  logic              slot_free;
  logic              is_halt;

  instr_fetch_prog_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .reset      (reset),
    .load_i     (pc_load),
    .load_val_i (bus.jump_target),
    .inc_i      (pc_inc),
    .pc_o       (pc)
  );

  assign slot_free = !instr_valid_q || bus.instr_ready;
  assign is_halt   = (bus.rom_data == HALT_WORD);

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    // a presented word drops once accepted unless a new capture replaces it
    instr_valid_d = instr_valid_q && !bus.instr_ready;
    halted_d      = halted_q;
    pc_load       = 1'b0;
    pc_inc        = 1'b0;

    if (bus.jump) begin
      pc_load       = 1'b1;
      instr_valid_d = 1'b0;
      halted_d      = 1'b0;
      state_d       = bus.run ? ST_FETCH : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.run) begin
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (!bus.run) begin
            state_d = ST_IDLE;
          end else if (slot_free) begin
            instr_d       = bus.rom_data;
            instr_pc_d    = pc;
            instr_valid_d = 1'b1;
            if (is_halt) begin
              state_d  = ST_HALT;
              halted_d = 1'b1;
            end else begin
              pc_inc = 1'b1;
            end
          end
        end
        ST_HALT: begin
          halted_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign bus.rom_addr    = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.halted      = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch with a behavioural 256x16 ROM.
`default_nettype none

module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic [15:0] rom [256];
  int          n_checks = 0;
  int          n_errors = 0;

  instr_fetch_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  instr_fetch #(
    .ADDR_W    (8),
    .DATA_W    (16),
    .RESET_PC  (8'h00),
    .HALT_WORD (16'hFFFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.rom_data = rom[bus.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_instr(input string tag, input logic [15:0] word, input logic [7:0] pc);
    check_val({tag, " valid"}, 32'(bus.instr_valid), 32'd1);
    check_val({tag, " instr"}, 32'(bus.instr), 32'(word));
    check_val({tag, " instr_pc"}, 32'(bus.instr_pc), 32'(pc));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
    rom[0] = 16'h1111;
    rom[1] = 16'h2222;
    rom[2] = 16'h3333;
    rom[3] = 16'h4444;
    rom[4] = 16'h5555;
    rom[5] = 16'hFFFF;

    reset           = 1'b1;
    bus.run         = 1'b0;
    bus.instr_ready = 1'b0;
    bus.jump        = 1'b0;
    bus.jump_target = 8'h00;
    tick();
    tick();
    check_val("rst valid", 32'(bus.instr_valid), 32'd0);
    check_val("rst instr", 32'(bus.instr), 32'd0);
    check_val("rst instr_pc", 32'(bus.instr_pc), 32'd0);
    check_val("rst halted", 32'(bus.halted), 32'd0);
    check_val("rst rom_addr", 32'(bus.rom_addr), 32'h00);
    reset = 1'b0;

    tick();
    tick();
    check_val("idle valid", 32'(bus.instr_valid), 32'd0);
    check_val("idle rom_addr", 32'(bus.rom_addr), 32'h00);

    bus.run         = 1'b1;
    bus.instr_ready = 1'b1;
    tick();
    check_val("start valid", 32'(bus.instr_valid), 32'd0);
    tick();
    expect_instr("seq0", 16'h1111, 8'h00);
    tick();
    expect_instr("seq1", 16'h2222, 8'h01);

    bus.instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_instr("stall", 16'h2222, 8'h01);
      check_val("stall rom_addr", 32'(bus.rom_addr), 32'h02);
    end
    bus.instr_ready = 1'b1;
    tick();
    expect_instr("seq2", 16'h3333, 8'h02);
    tick();
    expect_instr("seq3", 16'h4444, 8'h03);

    bus.jump        = 1'b1;
    bus.jump_target = 8'h40;
    tick();
    bus.jump = 1'b0;
    check_val("jmp40 valid", 32'(bus.instr_valid), 32'd0);
    check_val("jmp40 rom_addr", 32'(bus.rom_addr), 32'h40);
    tick();
    expect_instr("jmp40 t0", 16'h1040, 8'h40);
    tick();
    expect_instr("jmp40 t1", 16'h1041, 8'h41);

    bus.jump        = 1'b1;
    bus.jump_target = 8'hFE;
    tick();
    bus.jump = 1'b0;
    check_val("jmpFE valid", 32'(bus.instr_valid), 32'd0);
    tick();
    expect_instr("wrapFE", 16'h10FE, 8'hFE);
    tick();
    expect_instr("wrapFF", 16'h10FF, 8'hFF);
    tick();
    expect_instr("wrap00", 16'h1111, 8'h00);
    tick();
    expect_instr("w01", 16'h2222, 8'h01);
    tick();
    expect_instr("w02", 16'h3333, 8'h02);
    tick();
    expect_instr("w03", 16'h4444, 8'h03);
    tick();
    expect_instr("w04", 16'h5555, 8'h04);
    check_val("pre-halt halted", 32'(bus.halted), 32'd0);
    tick();
    expect_instr("halt word", 16'hFFFF, 8'h05);
    check_val("halt halted", 32'(bus.halted), 32'd1);
    check_val("halt rom_addr", 32'(bus.rom_addr), 32'h05);

    bus.instr_ready = 1'b0;
    tick();
    tick();
    expect_instr("halt hold", 16'hFFFF, 8'h05);
    bus.instr_ready = 1'b1;
    tick();
    check_val("halt drained valid", 32'(bus.instr_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("halt idle valid", 32'(bus.instr_valid), 32'd0);
      check_val("halt idle halted", 32'(bus.halted), 32'd1);
      check_val("halt idle rom_addr", 32'(bus.rom_addr), 32'h05);
    end

    bus.jump        = 1'b1;
    bus.jump_target = 8'h10;
    tick();
    bus.jump = 1'b0;
    check_val("resume halted", 32'(bus.halted), 32'd0);
    check_val("resume valid", 32'(bus.instr_valid), 32'd0);
    check_val("resume rom_addr", 32'(bus.rom_addr), 32'h10);
    tick();
    expect_instr("resume t0", 16'h1010, 8'h10);
    tick();
    expect_instr("resume t1", 16'h1011, 8'h11);
    bus.instr_ready = 1'b0;
    tick();
    expect_instr("pre-reset stall", 16'h1011, 8'h11);

    #2 reset = 1'b1;
    #1;
    check_val("async valid", 32'(bus.instr_valid), 32'd0);
    check_val("async instr", 32'(bus.instr), 32'd0);
    check_val("async instr_pc", 32'(bus.instr_pc), 32'd0);
    check_val("async halted", 32'(bus.halted), 32'd0);
    check_val("async rom_addr", 32'(bus.rom_addr), 32'h00);
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the e418 processor: holds the 8-bit program counter and drives the address of the asynchronous-read 256×16 program ROM. It registers the returned 16-bit word into an instruction register and hands it downstream with a valid/ready handshake. It handles sequential increment, jump/flush requests from execute, run/stop control and a halt word.

## Interface
- ADDR_W, 8, PC / ROM address width
- DATA_W, 16, instruction width
- RESET_PC, 8'h00, PC value after reset
- HALT_WORD, 16'hFFFF, instruction encoding that stops fetching
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  fetch enable; 0 = no new fetches
- rom_addr  out  ADDR_W  address to program ROM (= PC register, combinational)
- rom_data  in  DATA_W  ROM word for rom_addr, valid same cycle
- instr  out  DATA_W  registered instruction
- instr_pc  out  ADDR_W  address instr was fetched from
- instr_valid  out  1  instr/instr_pc hold a valid instruction
- instr_ready  in  1  downstream accepts instr this cycle
- jump  in  1  redirect request (one-cycle pulse)
- jump_target  in  ADDR_W  new PC when jump=1
- halted  out  1  fetch stopped by HALT_WORD

## Operation
- States: IDLE, FETCH, HALT. Reset → IDLE.
- Reset values: pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0.
- Slot free = !instr_valid || instr_ready.
- IDLE: no capture, pc held. run=1 → FETCH next cycle.
- FETCH, slot free, no jump: instr←rom_data, instr_pc←pc, instr_valid←1.
  - rom_data≠HALT_WORD: pc←pc+1, mod 256; 8'hFF wraps to 8'h00.
  - rom_data=HALT_WORD: pc held, → HALT.
- FETCH, slot not free: all registers hold (stall), instr stable.
- FETCH with run=0: finish nothing new, → IDLE; a pending valid instr stays until accepted.
- HALT: halted=1; the halt word remains presented until accepted, then instr_valid←0; no fetches.
- jump=1 (any state, highest priority): pc←jump_target, instr_valid←0, halted←0. Next state is FETCH if run=1, else IDLE. The word currently on rom_data is discarded, and so is any instr not accepted this same cycle.
- jump and instr_ready in the same cycle: the transfer of the current instr counts as done, then flush.
- Reset mid-operation: immediate return to reset values regardless of state or handshake.

## Timing
- rom_addr follows pc with zero cycles of latency; rom_data is sampled in the same cycle.
- Fetch latency: pc presented in cycle n → instr_valid=1 with that word after edge n.
- Throughput: 1 instruction/cycle while instr_ready=1.
- Jump penalty: jump in cycle n → instr_valid=0 in cycle n+1. The target instruction is valid in cycle n+2.
- IDLE→FETCH: first valid instruction 2 edges after run rises.
- halted rises on the edge that captures HALT_WORD.

## Structure
- Shared package/header e418_defs: state encoding (IDLE/FETCH/HALT), HALT_WORD, ADDR_W/DATA_W defaults.
- One sub-module, prog_counter: PC register with async reset, load (jump) and increment enables; wraps modulo 2^ADDR_W.
- FSM, instruction register and handshake logic live in instr_fetch; the ROM is instantiated at the level above.

## Test plan
- Reset, run=1, ROM[0..3]=1111,2222,3333,4444, ready=1 → instr 1111,2222,3333,4444 on consecutive cycles, instr_pc 00..03.
- Stall: ready=0 for 3 cycles while instr=2222 valid → instr, instr_pc and rom_addr frozen. ready=1 → 3333 next.
- Jump: jump=1, target=8'h40 while instr=1111 valid → valid=0 for one cycle, then instr=ROM[40], instr_pc=40.
- Wrap: jump to 8'hFE, ROM[FE],ROM[FF],ROM[00] delivered in order with instr_pc FE,FF,00.
- Halt: ROM[05]=FFFF → halted=1 after capture, FFFF delivered once, then instr_valid=0 indefinitely. Jump to 10 → halted=0, fetch resumes at 10.
- Async reset asserted mid-stall with valid instr → all outputs reset immediately without a clock edge, rom_addr=RESET_PC.
